// File: rtl/program_memory.sv
// Loadable instruction memory: registered CPU read port plus a valid/ready
// word-stream loader that stalls the CPU and sums the words it writes.
//
// state  | meaning
// S_IDLE | no load since reset; CPU reads allowed
// S_LOAD | accepting loader beats; CPU held, reads ignored
// S_DONE | load finished; CPU reads allowed, load_done high
module program_memory #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dataout,
   output logic              rd_valid,
   output logic              cpu_hold,
   input  logic              load_start,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_valid,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count,
   output logic [DATA_W-1:0] ld_sum
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              rv_q, rv_d;
   logic              hold_q, hold_d;
   logic              rdy_q, rdy_d;
   logic              done_q, done_d;
   logic              wr_en;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      sum_d    = sum_q;
      dout_d   = dout_q;
      rv_d     = 1'b0;
      wr_en    = 1'b0;

      if (state_q != S_LOAD && rd_en) begin
         rv_d   = 1'b1;
         dout_d = ({1'b0, address} < DEPTH_C) ? mem[address[IDX_W-1:0]] : '0;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (load_start) begin
               state_d  = S_LOAD;
               wr_ptr_d = '0;
               sum_d    = '0;
            end
         end
         S_LOAD: begin
            // a restart outranks a beat presented in the same cycle
            if (load_start) begin
               wr_ptr_d = '0;
               sum_d    = '0;
            end else if (ld_valid) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               sum_d    = sum_q + ld_data;
               if (ld_last || wr_ptr_q == LAST_C) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      hold_d = (state_d == S_LOAD);
      rdy_d  = (state_d == S_LOAD);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         sum_q    <= '0;
         dout_q   <= '0;
         rv_q     <= 1'b0;
         hold_q   <= 1'b0;
         rdy_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         sum_q    <= sum_d;
         dout_q   <= dout_d;
         rv_q     <= rv_d;
         hold_q   <= hold_d;
         rdy_q    <= rdy_d;
         done_q   <= done_d;
      end
   end

   // array is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[IDX_W-1:0]] <= ld_data;
   end

   assign dataout    = dout_q;
   assign rd_valid   = rv_q;
   assign cpu_hold   = hold_q;
   assign ld_ready   = rdy_q;
   assign load_done  = done_q;
   assign load_count = wr_ptr_q;
   assign ld_sum     = sum_q;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory (DEPTH=16): vector table for the basic
// load/read flow, hand sequences for overflow, restart and mid-load reset.
module tb_program_memory;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] address;
   logic          rd_en;
   logic [DW-1:0] dataout;
   logic          rd_valid;
   logic          cpu_hold;
   logic          load_start;
   logic [DW-1:0] ld_data;
   logic          ld_valid;
   logic          ld_last;
   logic          ld_ready;
   logic          load_done;
   logic [AW:0]   load_count;
   logic [DW-1:0] ld_sum;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   program_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_FILE("")) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .rd_en(rd_en),
      .dataout(dataout), .rd_valid(rd_valid), .cpu_hold(cpu_hold),
      .load_start(load_start), .ld_data(ld_data), .ld_valid(ld_valid),
      .ld_last(ld_last), .ld_ready(ld_ready), .load_done(load_done),
      .load_count(load_count), .ld_sum(ld_sum)
   );

   typedef struct {
      logic       ls, lv;
      logic [7:0] ld;
      logic       ll, re;
      logic [7:0] a;
      logic       e_rdy, e_hold, e_done, e_rv;
      logic [7:0] e_do;
      logic [8:0] e_cnt;
      logic [7:0] e_sum;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(logic ls, logic lv, logic [7:0] ld, logic ll,
                               logic re, logic [7:0] a, logic rdy, logic hold,
                               logic done, logic rv, logic [7:0] dout,
                               logic [8:0] cnt, logic [7:0] sum);
      vec_t v;
      v.ls = ls; v.lv = lv; v.ld = ld; v.ll = ll; v.re = re; v.a = a;
      v.e_rdy = rdy; v.e_hold = hold; v.e_done = done; v.e_rv = rv;
      v.e_do = dout; v.e_cnt = cnt; v.e_sum = sum;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ls, input logic lv, input logic [7:0] ld,
                        input logic ll, input logic re, input logic [7:0] a);
      load_start = ls; ld_valid = lv; ld_data = ld; ld_last = ll;
      rd_en = re; address = a;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
      drive(0, 0, 8'h00, 0, 1, a);
      step();
      chk({name, "_rv"}, 32'(rd_valid), 32'd1);
      chk({name, "_do"}, 32'(dataout), 32'(exp));
   endtask

   initial begin
      //          ls lv ld     ll re a      rdy hold done rv dout   cnt sum
      tbl[0]  = mk(1, 0, 8'h00, 0, 0, 8'd0,  1, 1, 0, 0, 8'h00, 0, 8'h00);
      tbl[1]  = mk(0, 1, 8'h30, 0, 0, 8'd0,  1, 1, 0, 0, 8'h00, 1, 8'h30);
      tbl[2]  = mk(0, 1, 8'h86, 1, 0, 8'd0,  0, 0, 1, 0, 8'h00, 2, 8'hB6);
      tbl[3]  = mk(0, 0, 8'h00, 0, 1, 8'd0,  0, 0, 1, 1, 8'h30, 2, 8'hB6);
      tbl[4]  = mk(0, 0, 8'h00, 0, 1, 8'd1,  0, 0, 1, 1, 8'h86, 2, 8'hB6);
      tbl[5]  = mk(0, 0, 8'h00, 0, 0, 8'd0,  0, 0, 1, 0, 8'h86, 2, 8'hB6);
      tbl[6]  = mk(1, 0, 8'h00, 0, 1, 8'd0,  1, 1, 0, 1, 8'h30, 0, 8'h00);
      tbl[7]  = mk(0, 1, 8'h01, 0, 0, 8'd0,  1, 1, 0, 0, 8'h30, 1, 8'h01);
      tbl[8]  = mk(0, 0, 8'h77, 0, 1, 8'd1,  1, 1, 0, 0, 8'h30, 1, 8'h01);
      tbl[9]  = mk(0, 1, 8'h02, 0, 1, 8'd1,  1, 1, 0, 0, 8'h30, 2, 8'h03);
      tbl[10] = mk(0, 0, 8'h00, 0, 1, 8'd1,  1, 1, 0, 0, 8'h30, 2, 8'h03);
      tbl[11] = mk(0, 1, 8'h03, 0, 0, 8'd0,  1, 1, 0, 0, 8'h30, 3, 8'h06);
      tbl[12] = mk(0, 1, 8'hFF, 1, 0, 8'd0,  0, 0, 1, 0, 8'h30, 4, 8'h05);
      tbl[13] = mk(0, 1, 8'hAA, 0, 1, 8'd0,  0, 0, 1, 1, 8'h01, 4, 8'h05);
      tbl[14] = mk(0, 0, 8'h00, 0, 1, 8'd1,  0, 0, 1, 1, 8'h02, 4, 8'h05);
      tbl[15] = mk(0, 0, 8'h00, 0, 1, 8'd2,  0, 0, 1, 1, 8'h03, 4, 8'h05);
      tbl[16] = mk(0, 0, 8'h00, 0, 1, 8'd3,  0, 0, 1, 1, 8'hFF, 4, 8'h05);
      tbl[17] = mk(0, 0, 8'h00, 0, 1, 8'd16, 0, 0, 1, 1, 8'h00, 4, 8'h05);
      tbl[18] = mk(0, 0, 8'h00, 0, 1, 8'd4,  0, 0, 1, 1, 8'hAA, 4, 8'h05);
      tbl[19] = mk(0, 0, 8'h00, 0, 0, 8'd0,  0, 0, 1, 0, 8'hAA, 4, 8'h05);
      // row 18: the beat offered in row 13 after DONE must not have been written
      tbl[18].e_do = 8'h00;
      tbl[19].e_do = 8'h00;
      // row 18 reads address 4, never loaded yet; pre-load it below instead
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 0, 0, 8'd0);
      step();
      step();
      chk("rst_rdy",  32'(ld_ready),   32'd0);
      chk("rst_hold", 32'(cpu_hold),   32'd0);
      chk("rst_done", 32'(load_done),  32'd0);
      chk("rst_rv",   32'(rd_valid),   32'd0);
      chk("rst_do",   32'(dataout),    32'd0);
      chk("rst_cnt",  32'(load_count), 32'd0);
      chk("rst_sum",  32'(ld_sum),     32'd0);
      rst_n = 1'b1;
      step();

      // give address 4 a known zero so the table row 18 expectation is defined
      drive(1, 0, 8'h00, 0, 0, 8'd0); step();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 8'h00, (i == 4), 0, 8'd0); step();
      end
      rst_n = 1'b0; step(); rst_n = 1'b1; step();

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].ls, tbl[i].lv, tbl[i].ld, tbl[i].ll, tbl[i].re, tbl[i].a);
         step();
         chk($sformatf("v%0d_rdy", i),  32'(ld_ready),   32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_hold", i), 32'(cpu_hold),   32'(tbl[i].e_hold));
         chk($sformatf("v%0d_done", i), 32'(load_done),  32'(tbl[i].e_done));
         chk($sformatf("v%0d_rv", i),   32'(rd_valid),   32'(tbl[i].e_rv));
         chk($sformatf("v%0d_do", i),   32'(dataout),    32'(tbl[i].e_do));
         chk($sformatf("v%0d_cnt", i),  32'(load_count), 32'(tbl[i].e_cnt));
         chk($sformatf("v%0d_sum", i),  32'(ld_sum),     32'(tbl[i].e_sum));
      end

      // overflow: 20 beats, no ld_last, only DEPTH accepted
      drive(1, 0, 8'h00, 0, 0, 8'd0); step();
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 8'(i + 1), 0, 0, 8'd0); step();
         chk($sformatf("ovf%0d_rdy", i), 32'(ld_ready), (i < 15) ? 32'd1 : 32'd0);
      end
      drive(0, 0, 8'h00, 0, 0, 8'd0); step();
      chk("ovf_cnt",  32'(load_count), 32'd16);
      chk("ovf_sum",  32'(ld_sum),     32'h88);
      chk("ovf_done", 32'(load_done),  32'd1);
      read_chk("ovf_a15", 8'd15, 8'h10);
      read_chk("ovf_a16", 8'd16, 8'h00);
      read_chk("ovf_a0",  8'd0,  8'h01);

      // restart mid-load with a simultaneous valid beat
      drive(1, 0, 8'h00, 0, 0, 8'd0); step();
      drive(0, 1, 8'hAA, 0, 0, 8'd0); step();
      drive(0, 1, 8'hBB, 0, 0, 8'd0); step();
      chk("rs_cnt2", 32'(load_count), 32'd2);
      drive(1, 1, 8'hCC, 0, 0, 8'd0); step();
      chk("rs_cnt0", 32'(load_count), 32'd0);
      chk("rs_sum0", 32'(ld_sum),     32'd0);
      chk("rs_hold", 32'(cpu_hold),   32'd1);
      drive(0, 1, 8'h11, 1, 0, 8'd0); step();
      chk("rs_done", 32'(load_done),  32'd1);
      chk("rs_cnt1", 32'(load_count), 32'd1);
      chk("rs_sum1", 32'(ld_sum),     32'h11);
      read_chk("rs_a0", 8'd0, 8'h11);
      read_chk("rs_a1", 8'd1, 8'hBB);
      read_chk("rs_a2", 8'd2, 8'h03);

      // mid-load asynchronous reset
      drive(1, 0, 8'h00, 0, 0, 8'd0); step();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 8'(8'h40 + i), (i == 5), 0, 8'd0); step();
      end
      read_chk("ar_old0", 8'd0, 8'h40);
      drive(1, 0, 8'h00, 0, 0, 8'd0); step();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 8'(8'h50 + i), 0, 0, 8'd0); step();
      end
      drive(0, 0, 8'h00, 0, 0, 8'd0);
      chk("ar_pre_hold", 32'(cpu_hold),   32'd1);
      chk("ar_pre_cnt",  32'(load_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_hold", 32'(cpu_hold),   32'd0);
      chk("ar_rdy",  32'(ld_ready),   32'd0);
      chk("ar_done", 32'(load_done),  32'd0);
      chk("ar_cnt",  32'(load_count), 32'd0);
      chk("ar_sum",  32'(ld_sum),     32'd0);
      chk("ar_rv",   32'(rd_valid),   32'd0);
      chk("ar_do",   32'(dataout),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         read_chk($sformatf("ar_mem%0d", i), 8'(i), (i < 3) ? 8'(8'h50 + i) : 8'(8'h40 + i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
